// File: rtl/mar_mdr_ctrl_pkg.sv
// mem_pkg -- shared definitions for the MAR/MDR memory-interface stage.
//
// Contents:
//   state_t        access FSM states (IDLE, REQ, WAIT, DONE)
//   ADDR_W_DEF     default MAR / memory address width
//   DATA_W_DEF     default MDR / bus / memory data width
//   TIMEOUT_DEF    default number of cycles to wait for mem_ack
//   TIMEOUT_FILL   value loaded into MDR when an access times out
//
// Optional feature macro used by the files that import this package:
//   MDR_PARITY_EN  even-parity checking of memory read data

package mem_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;

  // Wide enough for any practical DATA_W; users slice the low bits.
  localparam logic [63:0] TIMEOUT_FILL = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mar_mdr_ctrl_if.sv
// mar_mdr_ctrl_if -- request/acknowledge bus between the MAR/MDR stage and
// the memory array.
//
// Signals:
//   mem_req    controller -> memory  access request
//   mem_we     controller -> memory  write qualifier, valid while mem_req
//   mem_addr   controller -> memory  address (MAR contents)
//   mem_wdata  controller -> memory  write data (MDR contents)
//   mem_rdata  memory -> controller  read data, valid with mem_ack
//   mem_ack    memory -> controller  one-cycle completion
//   mem_rpar   memory -> controller  even parity over mem_rdata
//                                    (only when MDR_PARITY_EN is defined)
//
// Modports: master (controller side), slave (memory side).

interface mar_mdr_ctrl_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_pkg::DATA_W_DEF
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

`ifdef MDR_PARITY_EN
  logic              mem_rpar;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack, mem_rpar
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack, mem_rpar
  );
`else
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
`endif

endinterface

// File: rtl/mar_mdr_ctrl_wait_timer.sv
// wait_timer -- 8-bit saturating wait-state counter.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   clr      in   synchronous clear, wins over en
//   en       in   count up by one; holds at 8'hFF instead of wrapping
//   expired  out  count == TIMEOUT
//
// Parameter TIMEOUT: 1..255.

module wait_timer #(
  parameter int TIMEOUT = mem_pkg::TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/mar_mdr_ctrl.sv
// mar_mdr_ctrl -- memory-interface stage holding MAR and MDR and running a
// request/acknowledge access against memory, with a wait-state timeout.
//
// Parameters:
//   ADDR_W   MAR / memory address width (must not exceed DATA_W)
//   DATA_W   MDR / bus / memory data width
//   TIMEOUT  cycles to wait for mem_ack before giving up, 1..255
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   ldmar       load MAR from bus_in low bits (IDLE only)
//   ldmdr       load MDR from bus_in (IDLE only)
//   mem_en      start an access (accepted in IDLE only)
//   r_w         access direction, 1 = write, 0 = read
//   bus_in      CPU bus
//   mar_q       MAR contents
//   mdr_q       MDR contents
//   ready       access complete, one-cycle pulse
//   err         sticky timeout flag, cleared by the next accepted mem_en
//   perr        sticky read-parity error (only with MDR_PARITY_EN)
//   mem         memory bus, master side (see mar_mdr_ctrl_if)
//
// Optional feature macro: MDR_PARITY_EN -- checks mem_rpar against the even
// parity of mem_rdata on each read acknowledge and reports it on perr.

module mar_mdr_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ldmar,
  input  logic              ldmdr,
  input  logic              mem_en,
  input  logic              r_w,
  input  logic [DATA_W-1:0] bus_in,
  output logic [ADDR_W-1:0] mar_q,
  output logic [DATA_W-1:0] mdr_q,
  output logic              ready,
  output logic              err,
`ifdef MDR_PARITY_EN
  output logic              perr,
`endif
  mar_mdr_ctrl_if.master    mem
);

  state_t state;
  state_t state_nxt;

  logic r_w_lat;
  logic busy;
  logic accept;
  logic ack_hit;
  logic timed_out;
  logic expired;

  assign busy      = (state == REQ) || (state == WAIT);
  assign accept    = (state == IDLE) && mem_en;
  // Acknowledge takes priority over an expiring timer in the same cycle.
  assign ack_hit   = busy && mem.mem_ack;
  assign timed_out = busy && !mem.mem_ack && expired;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (busy && !mem.mem_ack && !expired),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_en) state_nxt = REQ;
      REQ,
      WAIT: begin
        if (ack_hit || timed_out) state_nxt = DONE;
        else                      state_nxt = WAIT;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // MAR and MDR only change in IDLE or at the end of an access, so
  // mem_addr/mem_wdata are stable for the whole request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_q   <= '0;
      mdr_q   <= '0;
      r_w_lat <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (state == IDLE && ldmar) mar_q <= bus_in[ADDR_W-1:0];

      if (state == IDLE && ldmdr)   mdr_q <= bus_in;
      else if (ack_hit && !r_w_lat) mdr_q <= mem.mem_rdata;
      else if (timed_out)           mdr_q <= TIMEOUT_FILL[DATA_W-1:0];

      if (accept) r_w_lat <= r_w;

      if (accept)         err <= 1'b0;
      else if (timed_out) err <= 1'b1;
    end
  end

`ifdef MDR_PARITY_EN
  // Even parity: mem_rpar should equal the XOR of the data bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr <= 1'b0;
    end else if (accept) begin
      perr <= 1'b0;
    end else if (ack_hit && !r_w_lat) begin
      perr <= (^mem.mem_rdata) != mem.mem_rpar;
    end
  end
`endif

  assign ready         = (state == DONE);
  assign mem.mem_req   = busy;
  assign mem.mem_we    = busy && r_w_lat;
  assign mem.mem_addr  = mar_q;
  assign mem.mem_wdata = mdr_q;

endmodule

// File: tb/tb_mar_mdr_ctrl.sv
// tb_mar_mdr_ctrl -- directed self-checking bench for mar_mdr_ctrl with
// TIMEOUT = 4. Builds with or without MDR_PARITY_EN.

module tb_mar_mdr_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ldmar;
  logic        ldmdr;
  logic        mem_en;
  logic        r_w;
  logic [15:0] bus_in;
  logic [15:0] mar_q;
  logic [15:0] mdr_q;
  logic        ready;
  logic        err;
  logic        perr_obs;
  logic        rpar;

  int checks;
  int errors;

  mar_mdr_ctrl_if #(.ADDR_W(16), .DATA_W(16)) mem_bus ();

  mar_mdr_ctrl #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ldmar  (ldmar),
    .ldmdr  (ldmdr),
    .mem_en (mem_en),
    .r_w    (r_w),
    .bus_in (bus_in),
    .mar_q  (mar_q),
    .mdr_q  (mdr_q),
    .ready  (ready),
    .err    (err),
`ifdef MDR_PARITY_EN
    .perr   (perr_obs),
`endif
    .mem    (mem_bus.master)
  );

`ifdef MDR_PARITY_EN
  assign mem_bus.mem_rpar = rpar;
`else
  assign perr_obs = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then drop the strobes.
  task automatic applyStimulus(input logic ld_a, input logic ld_d,
                               input logic en, input logic rw,
                               input logic [15:0] bus, input logic ack,
                               input logic [15:0] rdata, input logic par);
    ldmar             = ld_a;
    ldmdr             = ld_d;
    mem_en            = en;
    r_w               = rw;
    bus_in            = bus;
    mem_bus.mem_ack   = ack;
    mem_bus.mem_rdata = rdata;
    rpar              = par;
    @(posedge clk);
    #1;
    ldmar           = 1'b0;
    ldmdr           = 1'b0;
    mem_en          = 1'b0;
    mem_bus.mem_ack = 1'b0;
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    ldmar             = 1'b0;
    ldmdr             = 1'b0;
    mem_en            = 1'b0;
    r_w               = 1'b0;
    bus_in            = '0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    rpar              = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mar",   32'(mar_q), 32'h0);
    checkOutput("rst_mdr",   32'(mdr_q), 32'h0);
    checkOutput("rst_ready", 32'(ready), 32'h0);
    checkOutput("rst_err",   32'(err), 32'h0);
    checkOutput("rst_req",   32'(mem_bus.mem_req), 32'h0);
    checkOutput("rst_we",    32'(mem_bus.mem_we), 32'h0);
    rst_n = 1'b1;

    // Reset asserted mid-WAIT aborts without touching MDR
    applyStimulus(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0);
    applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'hDEAD, 0);
    checkOutput("abort_wait_req", 32'(mem_bus.mem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_req_drop", 32'(mem_bus.mem_req), 32'h0);
    checkOutput("abort_mdr",      32'(mdr_q), 32'h0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0);
    checkOutput("abort_ready", 32'(ready), 32'h0);

    // Read, zero wait states
    applyStimulus(1, 0, 0, 0, 16'h3001, 0, 16'h0000, 0);
    checkOutput("rd_mar", 32'(mar_q), 32'h3001);
    applyStimulus(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0);
    checkOutput("rd_c1_req",   32'(mem_bus.mem_req), 32'h1);
    checkOutput("rd_c1_we",    32'(mem_bus.mem_we), 32'h0);
    checkOutput("rd_c1_addr",  32'(mem_bus.mem_addr), 32'h3001);
    checkOutput("rd_c1_ready", 32'(ready), 32'h0);
    applyStimulus(0, 0, 0, 0, 16'h0000, 1, 16'hBEEF, 0);
    checkOutput("rd_c2_ready", 32'(ready), 32'h1);
    checkOutput("rd_c2_mdr",   32'(mdr_q), 32'hBEEF);
    checkOutput("rd_c2_req",   32'(mem_bus.mem_req), 32'h0);
    applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0);
    checkOutput("rd_c3_ready", 32'(ready), 32'h0);

    // Write, three wait states; ack carries junk read data that must be ignored
    applyStimulus(0, 1, 0, 0, 16'h1234, 0, 16'h0000, 0);
    applyStimulus(0, 0, 1, 1, 16'h0000, 0, 16'h0000, 0);
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("wr_c%0d_req", c),   32'(mem_bus.mem_req), 32'h1);
      checkOutput($sformatf("wr_c%0d_we", c),    32'(mem_bus.mem_we), 32'h1);
      checkOutput($sformatf("wr_c%0d_wdata", c), 32'(mem_bus.mem_wdata), 32'h1234);
      checkOutput($sformatf("wr_c%0d_ready", c), 32'(ready), 32'h0);
      applyStimulus(0, 0, 0, 0, 16'h0000, (c == 4), 16'h5555, 0);
    end
    checkOutput("wr_c5_ready", 32'(ready), 32'h1);
    checkOutput("wr_c5_mdr",   32'(mdr_q), 32'h1234);
    checkOutput("wr_c5_err",   32'(err), 32'h0);

    // Timeout with TIMEOUT = 4: ready/err in cycle 6
    applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0);
    applyStimulus(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0);
    for (int c = 1; c <= 5; c++) begin
      checkOutput($sformatf("to_c%0d_req", c),   32'(mem_bus.mem_req), 32'h1);
      checkOutput($sformatf("to_c%0d_ready", c), 32'(ready), 32'h0);
      applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0);
    end
    checkOutput("to_c6_ready", 32'(ready), 32'h1);
    checkOutput("to_c6_err",   32'(err), 32'h1);
    checkOutput("to_c6_mdr",   32'(mdr_q), 32'hFFFF);
    // mem_en in DONE is ignored
    applyStimulus(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0);
    checkOutput("to_done_en_req", 32'(mem_bus.mem_req), 32'h0);
    checkOutput("to_err_sticky",  32'(err), 32'h1);
    applyStimulus(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0);
    checkOutput("to_err_clear", 32'(err), 32'h0);
    checkOutput("to_next_req",  32'(mem_bus.mem_req), 32'h1);
    applyStimulus(0, 0, 0, 0, 16'h0000, 1, 16'hA5A5, 0);
    checkOutput("to_next_mdr", 32'(mdr_q), 32'hA5A5);
    applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0);

    // Same-cycle MAR load with mem_en, then a load while busy is ignored
    applyStimulus(1, 0, 1, 0, 16'h0040, 0, 16'h0000, 0);
    checkOutput("same_addr", 32'(mem_bus.mem_addr), 32'h0040);
    applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0);
    applyStimulus(1, 1, 1, 0, 16'h0050, 0, 16'h0000, 0);
    checkOutput("busy_mar",  32'(mar_q), 32'h0040);
    checkOutput("busy_mdr",  32'(mdr_q), 32'hA5A5);
    checkOutput("busy_req",  32'(mem_bus.mem_req), 32'h1);
    // Finish it with odd-weight data and wrong parity
    applyStimulus(0, 0, 0, 0, 16'h0000, 1, 16'h0001, 0);
    checkOutput("par1_ready", 32'(ready), 32'h1);
    checkOutput("par1_mdr",   32'(mdr_q), 32'h0001);
`ifdef MDR_PARITY_EN
    checkOutput("par1_perr",  32'(perr_obs), 32'h1);
`endif
    applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0);

    // Next read, even-weight data with parity 0 is correct
    applyStimulus(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0);
    applyStimulus(0, 0, 0, 0, 16'h0000, 1, 16'h0003, 0);
    checkOutput("par2_ready", 32'(ready), 32'h1);
    checkOutput("par2_mdr",   32'(mdr_q), 32'h0003);
`ifdef MDR_PARITY_EN
    checkOutput("par2_perr",  32'(perr_obs), 32'h0);
`endif
    applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0);

    // Ack while idle is ignored
    applyStimulus(0, 0, 0, 0, 16'h0000, 1, 16'h7777, 0);
    checkOutput("idle_ack_mdr",   32'(mdr_q), 32'h0003);
    checkOutput("idle_ack_ready", 32'(ready), 32'h0);
    checkOutput("idle_ack_req",   32'(mem_bus.mem_req), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mar_mdr_ctrl.md
# mar_mdr_ctrl

Memory-interface stage that sits directly upstream of the ROM/memory array. It holds the memory address register (MAR) and memory data register (MDR), loads them from the CPU bus, and runs a request/acknowledge transaction against the memory. It captures read data into MDR and signals completion (R) back to the control unit, with a wait-state timeout so a missing memory acknowledge cannot hang the control FSM.

## Interface
- `ADDR_W`, 16, MAR / memory address width
- `DATA_W`, 16, MDR / bus / memory data width
- `TIMEOUT`, 15, maximum cycles to wait for `mem_ack`, range 1..255
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ldmar`  in  1  load MAR from `bus_in`
- `ldmdr`  in  1  load MDR from `bus_in`
- `mem_en`  in  1  start a memory access (one-cycle pulse or level)
- `r_w`  in  1  access direction, 1 = write (MDR→memory), 0 = read
- `bus_in`  in  DATA_W  CPU bus; MAR takes the low ADDR_W bits
- `mar_q`  out  ADDR_W  MAR contents
- `mdr_q`  out  DATA_W  MDR contents
- `ready`  out  1  access complete (R), high for exactly one cycle
- `err`  out  1  sticky timeout flag, cleared by next `mem_en` accept
- `mem_req`  out  1  request to memory
- `mem_we`  out  1  write strobe qualifier, valid while `mem_req`
- `mem_addr`  out  ADDR_W  equals `mar_q`
- `mem_wdata`  out  DATA_W  equals `mdr_q`
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`
- `mem_ack`  in  1  memory completion, one cycle

## Operation
- Reset values: `mar_q`=0, `mdr_q`=0, `ready`=0, `err`=0, `mem_req`=0, `mem_we`=0. FSM goes to IDLE and the counter is cleared. Reset mid-transaction aborts with no MDR update.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - `ldmar`/`ldmdr` load their register at the edge.
  - `mem_en`=1 latches `r_w`, clears `err`, clears the counter, and goes to REQ.
  - `ldmar` together with `mem_en` is legal; the access uses the newly loaded MAR. The same applies to `ldmdr` on a write.
- REQ/WAIT:
  - `mem_req`=1, `mem_we`=latched `r_w`.
  - `ldmar`/`ldmdr`/`mem_en` are ignored while busy.
  - On `mem_ack` during a read, MDR ← `mem_rdata`; on `mem_ack` during a write, MDR is unchanged. Either way the FSM goes to DONE.
  - Without `mem_ack`, REQ goes to WAIT and the counter increments. When the counter reaches TIMEOUT, the FSM goes to DONE with `err`=1 and MDR ← all-ones.
- DONE: `ready`=1 and `mem_req`=0 for one cycle, then return to IDLE. `mem_en` in DONE is ignored; the control unit re-asserts it in IDLE.
- `mem_ack` while not in REQ/WAIT is ignored.
- The counter is 8 bits and saturates; it never wraps.

## Timing
- `mem_en` sampled at edge 0 → `mem_req` high in cycle 1.
- Zero-wait memory (ack in cycle 1) → MDR updated at edge 1 → `ready`=1 in cycle 2. Minimum latency is 2 cycles from accept to `ready`.
- N wait cycles → `ready` in cycle 2+N.
- Timeout → `ready` and `err` in cycle TIMEOUT+2.
- Back-to-back accesses: the next `mem_en` is accepted in the cycle after `ready`, so the minimum issue interval is 3 cycles.
- `mem_addr`/`mem_wdata` are stable for the whole request because MAR/MDR are frozen while busy.

## Configuration
- `MDR_PARITY_EN`, defined:
  - Adds input `mem_rpar` (1 bit, even parity over `mem_rdata`, valid with `mem_ack`) and output `perr`, reset 0.
  - On a read ack, `perr` ← mismatch. `perr` is sticky until the next accepted `mem_en`.
  - MDR still loads the data.
- Not defined: no extra ports and no parity logic.

## Structure
- Shared package `mem_pkg`:
  - State enum (IDLE, REQ, WAIT, DONE).
  - Defaults for `ADDR_W`, `DATA_W`, `TIMEOUT`.
  - Timeout fill constant (all-ones).
- One sub-module, `wait_timer`: 8-bit saturating counter with clear, enable and `expired` (count == TIMEOUT) output.

## Test plan
- Reset → all outputs 0.
  - Assert `rst_n` low mid-WAIT → `mem_req` drops immediately and MDR is unchanged.
- Read, zero wait:
  - Stimulus: `ldmar` with `bus_in`=0x3001, then `mem_en`, `r_w`=0; memory acks in cycle 1 with 0xBEEF.
  - Expect: `mem_addr`=0x3001, `mdr_q`=0xBEEF and `ready`=1 in cycle 2.
- Write, 3 wait states:
  - Stimulus: `ldmdr` 0x1234, then `mem_en`, `r_w`=1; ack in cycle 4.
  - Expect: `mem_we`=1 and `mem_wdata`=0x1234 throughout, `ready` in cycle 5, MDR still 0x1234.
- Timeout, TIMEOUT=4:
  - Stimulus: no ack.
  - Expect: `ready`=1, `err`=1, `mdr_q`=0xFFFF in cycle 6; next `mem_en` clears `err`.
- Same-cycle and busy loads:
  - Stimulus: `ldmar`=0x0040 together with `mem_en` → expect `mem_addr`=0x0040.
  - Stimulus: `ldmar`=0x0050 during WAIT → expect it ignored, `mar_q` stays 0x0040.
- With `MDR_PARITY_EN`:
  - Stimulus: read 0x0001 with `mem_rpar`=0 → expect `perr`=1 at `ready`.
  - Stimulus: next read 0x0003 with `mem_rpar`=0 → expect `perr`=0.
